// File: rtl/lz4_pkg.sv
// Shared LZ4 encoder definitions: packer state encoding and accumulator geometry.
package lz4_pkg;

  localparam int unsigned DWORD_BYTES = 4;
  localparam int unsigned ACC_BYTES   = 8;
  localparam int unsigned DWORD_W     = DWORD_BYTES * 8;
  localparam int unsigned ACC_W       = ACC_BYTES * 8;
  localparam int unsigned FILL_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } pack_state_e;

endpackage

// File: rtl/byte_insert_64.sv
// Masks a 1..4 byte chunk to its length and ORs it into a 64b accumulator at a byte offset.
module byte_insert_64
  import lz4_pkg::*;
(
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [DWORD_W-1:0] data_i,
  input  logic [2:0]         nbytes_i,
  input  logic [2:0]         offset_i,
  output logic [ACC_W-1:0]   acc_o
);

  logic [DWORD_W-1:0] mask;
  logic [ACC_W-1:0]   chunk;

  always_comb begin
    mask = '0;
    for (int unsigned b = 0; b < DWORD_BYTES; b++) begin
      if (3'(b) < nbytes_i) mask[8*b +: 8] = 8'hFF;
    end
    chunk = ACC_W'(data_i & mask);
    acc_o = acc_i | (chunk << 6'({offset_i, 3'b000}));
  end

endmodule

// File: rtl/byte_packer_v1.sv
// Packs 1..4 byte chunks into a byte-contiguous stream of 32-bit dwords for the output FIFO,
// draining a zero-padded tail dword on flush.
module byte_packer_v1
  import lz4_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             pack_en,
  input  logic             flush,
  input  logic [31:0]      in_data,
  input  logic [2:0]       in_nbytes,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             fifo_full,
  output logic [31:0]      fifo_wdata,
  output logic             fifo_wr_en,
  output logic [2:0]       last_nbytes,
  output logic [CNT_W-1:0] byte_total,
  output logic             pack_done,
  output logic             pack_busy,
  output logic             pack_error
);

  pack_state_e       state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_base_c, acc_ins_c;
  logic [FILL_W-1:0] fill_q, fill_d, fill_base_c;
  logic              take_c, accept_c, illegal_c, emit_c, tail_c;
  logic              run_entry_c, done_entry_c;
  logic [2:0]        last_final_c;

  // Room is judged before this cycle's emit so fill can never exceed 8
  assign in_ready = (state_q == ST_RUN) && (fill_q <= FILL_W'(DWORD_BYTES)) && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN:   if (flush) state_d = ST_FLUSH;
      ST_FLUSH: if ((fill_q == '0) && !fifo_wr_en) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (!pack_en) state_d = ST_IDLE;
  end

  always_comb begin
    take_c      = in_valid && in_ready && pack_en;
    accept_c    = take_c && (in_nbytes != 3'd0) && (in_nbytes <= 3'(DWORD_BYTES));
    illegal_c   = take_c && (in_nbytes > 3'(DWORD_BYTES));
    emit_c      = pack_en && (fill_q >= FILL_W'(DWORD_BYTES)) && !fifo_full &&
                  ((state_q == ST_RUN) || (state_q == ST_FLUSH));
    tail_c      = pack_en && (state_q == ST_FLUSH) && (fill_q != '0) &&
                  (fill_q < FILL_W'(DWORD_BYTES)) && !fifo_full;
    acc_base_c  = emit_c ? (acc_q >> DWORD_W) : acc_q;
    fill_base_c = emit_c ? (fill_q - FILL_W'(DWORD_BYTES)) : fill_q;
    acc_d       = accept_c ? acc_ins_c : acc_base_c;
    fill_d      = accept_c ? (fill_base_c + FILL_W'(in_nbytes)) : fill_base_c;
    run_entry_c  = (state_q == ST_IDLE) && (state_d == ST_RUN);
    done_entry_c = (state_q == ST_FLUSH) && (state_d == ST_DONE);
    // Final dword length follows from the byte count: a multiple of 4 means a full last dword
    if (byte_total == '0)               last_final_c = 3'd0;
    else if (byte_total[1:0] == 2'd0)   last_final_c = 3'd4;
    else                                last_final_c = {1'b0, byte_total[1:0]};
  end

  byte_insert_64 u_insert (
    .acc_i    (acc_base_c),
    .data_i   (in_data),
    .nbytes_i (in_nbytes),
    .offset_i (fill_base_c[2:0]),
    .acc_o    (acc_ins_c)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      fill_q      <= '0;
      fifo_wdata  <= '0;
      fifo_wr_en  <= 1'b0;
      last_nbytes <= '0;
      byte_total  <= '0;
      pack_done   <= 1'b0;
      pack_busy   <= 1'b0;
      pack_error  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pack_busy  <= (state_d == ST_RUN) || (state_d == ST_FLUSH);
      pack_done  <= done_entry_c;
      fifo_wr_en <= emit_c || tail_c;
      if (emit_c || tail_c) fifo_wdata <= acc_q[DWORD_W-1:0];

      if ((state_d == ST_IDLE) || tail_c) begin
        acc_q  <= '0;
        fill_q <= '0;
      end else begin
        acc_q  <= acc_d;
        fill_q <= fill_d;
      end

      if (run_entry_c)   byte_total <= '0;
      else if (accept_c) byte_total <= byte_total + CNT_W'(in_nbytes);

      if (run_entry_c)       last_nbytes <= '0;
      else if (done_entry_c) last_nbytes <= last_final_c;

      if (state_d == ST_IDLE) pack_error <= 1'b0;
      else if (illegal_c)     pack_error <= 1'b1;
    end
  end

endmodule
